// File: rtl/ibex_rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: source select and write record.
package ibex_rf_wb_arbiter_pkg;

  localparam int unsigned RfDataWidth = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LSU,
    WB_QUEUE,
    WB_EX
  } rf_wb_src_e;

  typedef struct packed {
    logic [4:0]             waddr;
    logic [RfDataWidth-1:0] wdata;
  } rf_wr_t;

  // RV32E has only 16 registers; bit 4 is dropped so a bad address still lands somewhere legal.
  function automatic logic [4:0] mask_addr(input logic [4:0] addr, input logic rv32e);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_queue.sv
// In-order FIFO of pending EX writes; entries are also exposed oldest-first for forwarding.
module ibex_rf_wb_queue
  import ibex_rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  rf_wr_t          push_data_i,
  input  logic            pop_i,
  output rf_wr_t          head_o,
  output logic [CntW-1:0] cnt_o,
  output rf_wr_t          entries_o [Depth],
  output logic [Depth-1:0] valid_o
);

  rf_wr_t          r_mem [Depth];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_cnt;

  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] ptr, input int unsigned k);
    int unsigned sum;
    sum = 32'(ptr) + k;
    if (sum >= Depth) sum = sum - Depth;
    return sum[PtrW-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (push_i) r_wr_ptr <= wrap_add(r_wr_ptr, 1);
      if (pop_i)  r_rd_ptr <= wrap_add(r_rd_ptr, 1);
      if (push_i && !pop_i)      r_cnt <= r_cnt + 1'b1;
      else if (pop_i && !push_i) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: the occupancy counter alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_data_i;
  end

  always_comb begin
    for (int k = 0; k < Depth; k++) begin
      entries_o[k] = r_mem[wrap_add(r_rd_ptr, k)];
      valid_o[k]   = (k < 32'(r_cnt));
    end
  end

  assign head_o = r_mem[r_rd_ptr];
  assign cnt_o  = r_cnt;

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Owns the RF write port: LSU first, then queued EX results, then EX pass-through; forwards to ID.
module ibex_rf_wb_arbiter
  import ibex_rf_wb_arbiter_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = RfDataWidth,
  parameter int unsigned PendDepth = 2,
  localparam int unsigned CntW     = $clog2(PendDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_we_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic [CntW-1:0]      pend_cnt_o,
  output logic                 err_o
);

  rf_wr_t             w_ex_wr;
  rf_wr_t             w_lsu_wr;
  rf_wr_t             w_head;
  rf_wr_t             w_entries [PendDepth];
  logic [PendDepth-1:0] w_valid;
  logic [CntW-1:0]    w_cnt;
  logic               w_ex_acc;
  logic               w_q_empty;
  logic               w_push;
  logic               w_pop;
  rf_wb_src_e         w_src;
  logic               r_err;

  assign w_ex_wr   = '{waddr: mask_addr(ex_waddr_i, RV32E),  wdata: ex_wdata_i};
  assign w_lsu_wr  = '{waddr: mask_addr(lsu_waddr_i, RV32E), wdata: lsu_wdata_i};
  assign w_q_empty = (w_cnt == '0);
  assign ex_ready_o = (w_cnt < CntW'(PendDepth));
  assign w_ex_acc  = ex_we_i && ex_ready_o;
  assign w_push    = w_ex_acc && (lsu_we_i || !w_q_empty);
  assign w_pop     = !lsu_we_i && !w_q_empty;

  ibex_rf_wb_queue #(.Depth(PendDepth)) u_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_push),
    .push_data_i (w_ex_wr),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .cnt_o       (w_cnt),
    .entries_o   (w_entries),
    .valid_o     (w_valid)
  );

  always_comb begin
    w_src = WB_NONE;
    if (lsu_we_i)        w_src = WB_LSU;
    else if (!w_q_empty) w_src = WB_QUEUE;
    else if (w_ex_acc)   w_src = WB_EX;
  end

  always_comb begin
    rf_we_o    = 1'b1;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    unique case (w_src)
      WB_LSU:   {rf_waddr_o, rf_wdata_o} = w_lsu_wr;
      WB_QUEUE: {rf_waddr_o, rf_wdata_o} = w_head;
      WB_EX:    {rf_waddr_o, rf_wdata_o} = w_ex_wr;
      default:  rf_we_o = 1'b0;
    endcase
  end

  // Later assignments override earlier ones, so the order below runs oldest to youngest.
  always_comb begin
    rdata_a_o = rf_rdata_a_i;
    rdata_b_o = rf_rdata_b_i;
    if (raddr_a_i != 5'd0) begin
      if (rf_we_o && rf_waddr_o == raddr_a_i) rdata_a_o = rf_wdata_o;
      for (int k = 0; k < PendDepth; k++)
        if (w_valid[k] && w_entries[k].waddr == raddr_a_i) rdata_a_o = w_entries[k].wdata;
      if (w_push && w_ex_wr.waddr == raddr_a_i) rdata_a_o = w_ex_wr.wdata;
    end
    if (raddr_b_i != 5'd0) begin
      if (rf_we_o && rf_waddr_o == raddr_b_i) rdata_b_o = rf_wdata_o;
      for (int k = 0; k < PendDepth; k++)
        if (w_valid[k] && w_entries[k].waddr == raddr_b_i) rdata_b_o = w_entries[k].wdata;
      if (w_push && w_ex_wr.waddr == raddr_b_i) rdata_b_o = w_ex_wr.wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (RV32E && ((w_ex_acc && ex_waddr_i[4]) || (lsu_we_i && lsu_waddr_i[4]))) begin
      r_err <= 1'b1;
    end
  end

  assign err_o      = r_err;
  assign pend_cnt_o = w_cnt;

endmodule
